regfile_mp: RTL

Parametrised multi-port integer register file for the next-generation pipelined datapath. Provides NRD combinational read ports and NWR synchronous write ports, plus a per-register busy scoreboard so the issue stage can detect read-after-write hazards. Register 0 is hardwired to zero. Sits between decode/issue (reads, scoreboard) and writeback (writes).

---
 rtl/regfile_mp.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised multi-port integer register file with a per-register
//            busy scoreboard for read-after-write hazard detection.
//            Register 0 is hardwired to zero and never becomes busy.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN  data width in bits
//   NREG  number of registers (power of two, >= 2); AW = $clog2(NREG)
//   NRD   number of combinational read ports (>= 1)
//   NWR   number of synchronous write ports (>= 1)
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears data and scoreboard)
//   rd_addr   in   NRD*AW   read addresses, port i at [i*AW +: AW]
//   rd_data   out  NRD*XLEN read data, port i at [i*XLEN +: XLEN]
//   rd_busy   out  NRD      scoreboard busy bit of each read address
//   wr_en     in   NWR      per-port write enable
//   wr_addr   in   NWR*AW   write addresses
//   wr_data   in   NWR*XLEN write data
//   iss_en    in   issue strobe, marks iss_addr busy
//   iss_addr  in   AW       destination register of the issuing instruction
//   busy_vec  out  NREG     full scoreboard, bit r = register r busy
// Build option
//   REGFILE_BYPASS_EN  when defined, read ports forward same-cycle write data
//                      (highest-index matching write port) and report not
//                      busy for the forwarded register.
// ============================================================================
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]         rd_data,
  output logic [NRD-1:0]              rd_busy,
  input  logic [NWR-1:0]              wr_en,
  input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0]         wr_data,
  input  logic                        iss_en,
  input  logic [$clog2(NREG)-1:0]     iss_addr,
  output logic [NREG-1:0]             busy_vec
);

  localparam int AW = $clog2(NREG);

  // Flat views of the stored state; element 0 is a constant zero.
  logic [XLEN-1:0] w_rf [NREG];
  logic [NREG-1:0] w_busy;

  // --------------------------------------------------------------------------
  // Storage: one register plus one busy flag per architectural register.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_rf[r]   = '0;
      assign w_busy[r] = 1'b0;
    end else begin : g_live
      logic [XLEN-1:0] r_data;
      logic            r_busy;
      logic            w_we;
      logic [XLEN-1:0] w_wd;
      logic            w_iss_hit;

      // Scan ports in ascending order so the highest-index enabled port
      // targeting this register supplies the data.
      always_comb begin
        w_we = 1'b0;
        w_wd = '0;
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
            w_we = 1'b1;
            w_wd = wr_data[j*XLEN +: XLEN];
          end
        end
      end

      assign w_iss_hit = iss_en && (iss_addr == AW'(r));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_we) begin
            r_data <= w_wd;
          end
          // A new producer issuing on the same edge as the old producer's
          // writeback keeps the register busy.
          if (w_iss_hit) begin
            r_busy <= 1'b1;
          end else if (w_we) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_rf[r]   = r_data;
      assign w_busy[r] = r_busy;
    end
  end

  assign busy_vec = w_busy;

  // --------------------------------------------------------------------------
  // Read ports: combinational, zero latency.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_raddr;
    logic [XLEN-1:0] w_stored;
    logic            w_sbusy;

    assign w_raddr  = rd_addr[i*AW +: AW];
    assign w_stored = w_rf[w_raddr];
    assign w_sbusy  = w_busy[w_raddr];

`ifdef REGFILE_BYPASS_EN
    logic            w_fwd_hit;
    logic [XLEN-1:0] w_fwd_data;

    // Forward from the highest-index enabled write port hitting this address.
    // Address 0 never forwards so x0 keeps reading zero.
    always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_raddr) && (w_raddr != '0)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = w_fwd_hit ? w_fwd_data : w_stored;
    assign rd_busy[i]              = w_fwd_hit ? 1'b0 : w_sbusy;
`else
    assign rd_data[i*XLEN +: XLEN] = w_stored;
    assign rd_busy[i]              = w_sbusy;
`endif
  end

endmodule
`default_nettype wire
